// File: rtl/fire_layer_sequencer_if.sv
// Handshake bundle between the fire-layer sequencer and its squeeze/expand engines.
// master drives the engine-side requests; slave is the sequencer.
interface fire_layer_sequencer_if #(parameter int WOUT = 32);
  localparam int AW = (WOUT*WOUT > 1) ? $clog2(WOUT*WOUT) : 1;

  logic          start;
  logic          sqz_sample, sqz_finish;
  logic          exp1_sample, exp1_finish;
  logic          exp3_sample, exp3_finish;
  logic          sqz_en, exp_en;
  logic          sqz_ram_feedback, exp1_ram_feedback, exp3_ram_feedback;
  logic          sqz_wr_en, exp1_wr_en, exp3_wr_en;
  logic [AW-1:0] sqz_wr_addr, exp1_wr_addr, exp3_wr_addr;
  logic          busy, done, error;

  modport master (
    output start, sqz_sample, sqz_finish, exp1_sample, exp1_finish, exp3_sample, exp3_finish,
    input  sqz_en, exp_en, sqz_ram_feedback, exp1_ram_feedback, exp3_ram_feedback,
           sqz_wr_en, exp1_wr_en, exp3_wr_en, sqz_wr_addr, exp1_wr_addr, exp3_wr_addr,
           busy, done, error
  );

  modport slave (
    input  start, sqz_sample, sqz_finish, exp1_sample, exp1_finish, exp3_sample, exp3_finish,
    output sqz_en, exp_en, sqz_ram_feedback, exp1_ram_feedback, exp3_ram_feedback,
           sqz_wr_en, exp1_wr_en, exp3_wr_en, sqz_wr_addr, exp1_wr_addr, exp3_wr_addr,
           busy, done, error
  );
endinterface

// File: rtl/fire_layer_sequencer.sv
// Sequences one fire module: squeeze layer, then both expand layers in parallel,
// generating RAM write addresses, finish acknowledges and a progress watchdog.
module fire_layer_sequencer #(
  parameter int WOUT    = 32,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  fire_layer_sequencer_if.slave bus
);
  localparam int NPIX = WOUT*WOUT;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = $clog2(NPIX+1);
  localparam int WW   = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] FULL    = CW'(NPIX);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT-1);

  typedef enum logic [2:0] {IDLE, SQZ_RUN, SQZ_ACK, EXP_RUN, EXP_ACK, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   sqz_cnt, e1_cnt, e3_cnt;
  logic            seen1, seen3;
  logic [WW-1:0]   wd;
  logic            start_ok, sqz_acc, e1_acc, e3_acc, any_acc;
  logic            sqz_ok, sqz_bad, e1_ok, e1_bad, e3_ok, e3_bad, tmo, fail;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    start_ok = (state == IDLE) && bus.start;
    sqz_acc  = (state == SQZ_RUN) && bus.sqz_sample  && (sqz_cnt != FULL);
    e1_acc   = (state == EXP_RUN) && bus.exp1_sample && (e1_cnt  != FULL);
    e3_acc   = (state == EXP_RUN) && bus.exp3_sample && (e3_cnt  != FULL);
    any_acc  = sqz_acc | e1_acc | e3_acc;
    sqz_ok   = (state == SQZ_RUN) && bus.sqz_finish  && (sqz_cnt == FULL);
    sqz_bad  = (state == SQZ_RUN) && bus.sqz_finish  && (sqz_cnt != FULL);
    // finish is a level; the seen flag turns it into a single acknowledge
    e1_ok    = (state == EXP_RUN) && bus.exp1_finish && (e1_cnt == FULL) && !seen1;
    e1_bad   = (state == EXP_RUN) && bus.exp1_finish && (e1_cnt != FULL);
    e3_ok    = (state == EXP_RUN) && bus.exp3_finish && (e3_cnt == FULL) && !seen3;
    e3_bad   = (state == EXP_RUN) && bus.exp3_finish && (e3_cnt != FULL);
    tmo      = 1'b0;
    state_n  = state;
    case (state)
      IDLE:    if (bus.start) state_n = SQZ_RUN;
      SQZ_RUN: if (sqz_ok) state_n = SQZ_ACK;
               else if (sqz_bad) state_n = IDLE;
      SQZ_ACK: state_n = EXP_RUN;
      EXP_RUN: if (e1_bad || e3_bad) state_n = IDLE;
               else if ((seen1 || e1_ok) && (seen3 || e3_ok)) state_n = EXP_ACK;
      EXP_ACK: state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // watchdog only fires when this cycle made no progress of its own
    if (state != IDLE && state_n == state && !any_acc && wd == WD_LAST) begin
      state_n = IDLE;
      tmo     = 1'b1;
    end
    fail = sqz_bad | e1_bad | e3_bad | tmo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sqz_cnt <= '0; e1_cnt <= '0; e3_cnt <= '0;
      seen1 <= 1'b0; seen3 <= 1'b0; wd <= '0;
      bus.sqz_en <= 1'b0; bus.exp_en <= 1'b0;
      bus.sqz_ram_feedback <= 1'b0; bus.exp1_ram_feedback <= 1'b0; bus.exp3_ram_feedback <= 1'b0;
      bus.sqz_wr_en <= 1'b0; bus.exp1_wr_en <= 1'b0; bus.exp3_wr_en <= 1'b0;
      bus.sqz_wr_addr <= '0; bus.exp1_wr_addr <= '0; bus.exp3_wr_addr <= '0;
      bus.busy <= 1'b0; bus.done <= 1'b0; bus.error <= 1'b0;
    end else begin
      if (start_ok) begin
        sqz_cnt <= '0; e1_cnt <= '0; e3_cnt <= '0;
        seen1 <= 1'b0; seen3 <= 1'b0;
      end else begin
        if (sqz_acc) sqz_cnt <= sqz_cnt + CW'(1);
        if (e1_acc)  e1_cnt  <= e1_cnt  + CW'(1);
        if (e3_acc)  e3_cnt  <= e3_cnt  + CW'(1);
        if (e1_ok)   seen1   <= 1'b1;
        if (e3_ok)   seen3   <= 1'b1;
      end
      if (state_n != state || any_acc) wd <= '0;
      else if (state != IDLE)          wd <= wd + WW'(1);

      bus.sqz_wr_en  <= sqz_acc;
      bus.exp1_wr_en <= e1_acc;
      bus.exp3_wr_en <= e3_acc;
      if (sqz_acc) bus.sqz_wr_addr  <= sqz_cnt[AW-1:0];
      if (e1_acc)  bus.exp1_wr_addr <= e1_cnt[AW-1:0];
      if (e3_acc)  bus.exp3_wr_addr <= e3_cnt[AW-1:0];

      bus.sqz_ram_feedback  <= sqz_ok;
      bus.exp1_ram_feedback <= e1_ok & ~tmo;
      bus.exp3_ram_feedback <= e3_ok & ~tmo;
      bus.sqz_en <= (state_n == SQZ_RUN);
      bus.exp_en <= (state_n == EXP_RUN);
      bus.busy   <= (state_n != IDLE);
      bus.done   <= (state_n == DONE);
      if (start_ok)  bus.error <= 1'b0;
      else if (fail) bus.error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fire_layer_sequencer.sv
// Directed bench for fire_layer_sequencer with WOUT=2, TIMEOUT=16.
module tb_fire_layer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cnt;

  always #5 clk = ~clk;

  fire_layer_sequencer_if #(.WOUT(2)) b();
  fire_layer_sequencer #(.WOUT(2), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(b));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start, four squeeze samples, finish, land in EXP_RUN
  task automatic run_sqz();
    b.start = 1'b1; tick(); b.start = 1'b0;
    repeat (4) begin b.sqz_sample = 1'b1; tick(); b.sqz_sample = 1'b0; end
    b.sqz_finish = 1'b1; tick(); b.sqz_finish = 1'b0; tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    b.start = 0; b.sqz_sample = 0; b.sqz_finish = 0;
    b.exp1_sample = 0; b.exp1_finish = 0; b.exp3_sample = 0; b.exp3_finish = 0;
    tick(); tick(); rst = 1'b0;
    chk("rst_busy", b.busy, 0);
    chk("rst_sqz_en", b.sqz_en, 0);
    chk("rst_error", b.error, 0);
    chk("rst_done", b.done, 0);

    // squeeze pass: writes 0..3, one acknowledge, expand enable two cycles after finish
    b.start = 1'b1; tick(); b.start = 1'b0;
    chk("start_sqz_en", b.sqz_en, 1);
    chk("start_busy", b.busy, 1);
    for (int i = 0; i < 4; i++) begin
      b.sqz_sample = 1'b1; tick(); b.sqz_sample = 1'b0;
      chk("sqz_wr_en", b.sqz_wr_en, 1);
      chk("sqz_wr_addr", b.sqz_wr_addr, i);
      if (i == 1) begin
        b.start = 1'b1; tick(); b.start = 1'b0;
        chk("start_ignored_wr", b.sqz_wr_en, 0);
        chk("start_ignored_en", b.sqz_en, 1);
      end
    end
    b.sqz_finish = 1'b1; tick(); b.sqz_finish = 1'b0;
    chk("sqz_fb", b.sqz_ram_feedback, 1);
    chk("sqz_en_off", b.sqz_en, 0);
    chk("exp_en_ack", b.exp_en, 0);
    tick();
    chk("sqz_fb_once", b.sqz_ram_feedback, 0);
    chk("exp_en_on", b.exp_en, 1);

    // interleaved expand samples, exp3 finishes 10 cycles after exp1
    for (int i = 0; i < 4; i++) begin
      b.exp1_sample = 1'b1; tick(); b.exp1_sample = 1'b0;
      chk("e1_wr_en", b.exp1_wr_en, 1);
      chk("e1_wr_addr", b.exp1_wr_addr, i);
      b.exp3_sample = 1'b1; tick(); b.exp3_sample = 1'b0;
      chk("e3_wr_en", b.exp3_wr_en, 1);
      chk("e3_wr_addr", b.exp3_wr_addr, i);
    end
    b.exp1_finish = 1'b1; tick();
    chk("e1_fb", b.exp1_ram_feedback, 1);
    chk("e1_fb_exp_en", b.exp_en, 1);
    cnt = 0;
    repeat (9) begin tick(); cnt += b.exp1_ram_feedback; end
    chk("e1_fb_once", cnt, 0);
    chk("e3_wait_done", b.done, 0);
    b.exp3_finish = 1'b1; tick();
    chk("e3_fb", b.exp3_ram_feedback, 1);
    chk("e3_fb_sep", b.exp1_ram_feedback, 0);
    chk("exp_ack_en", b.exp_en, 0);
    chk("exp_ack_done", b.done, 0);
    b.exp1_finish = 1'b0; b.exp3_finish = 1'b0; tick();
    chk("done_pulse", b.done, 1);
    tick();
    chk("done_once", b.done, 0);
    chk("idle_busy", b.busy, 0);

    // simultaneous expand finish
    run_sqz();
    for (int i = 0; i < 4; i++) begin
      b.exp1_sample = 1'b1; b.exp3_sample = 1'b1; tick();
      b.exp1_sample = 1'b0; b.exp3_sample = 1'b0;
      chk("sim_wr_both", {b.exp1_wr_en, b.exp3_wr_en}, 2'b11);
    end
    chk("sim_addr3", b.exp3_wr_addr, 3);
    b.exp1_finish = 1'b1; b.exp3_finish = 1'b1; tick();
    b.exp1_finish = 1'b0; b.exp3_finish = 1'b0;
    chk("sim_fb_both", {b.exp1_ram_feedback, b.exp3_ram_feedback}, 2'b11);
    chk("sim_exp_en", b.exp_en, 0);
    tick();
    chk("sim_done", b.done, 1);
    tick();

    // over-run of squeeze samples, then reset mid-expand
    b.start = 1'b1; tick(); b.start = 1'b0;
    cnt = 0;
    repeat (6) begin b.sqz_sample = 1'b1; tick(); b.sqz_sample = 1'b0; cnt += b.sqz_wr_en; end
    chk("ovr_writes", cnt, 4);
    chk("ovr_addr", b.sqz_wr_addr, 3);
    b.sqz_finish = 1'b1; tick(); b.sqz_finish = 1'b0;
    chk("ovr_fb", b.sqz_ram_feedback, 1);
    tick();
    b.exp1_sample = 1'b1; tick();
    chk("pre_rst_e1_wr", b.exp1_wr_en, 1);
    rst = 1'b1; b.exp1_finish = 1'b1; tick();
    rst = 1'b0; b.exp1_sample = 1'b0; b.exp1_finish = 1'b0;
    chk("rst_exp_en", b.exp_en, 0);
    chk("rst_e1_wr", b.exp1_wr_en, 0);
    chk("rst_e1_fb", b.exp1_ram_feedback, 0);
    chk("rst_busy2", b.busy, 0);

    // restart from address 0, then early squeeze finish
    b.start = 1'b1; tick(); b.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b.sqz_sample = 1'b1; tick(); b.sqz_sample = 1'b0;
      chk("restart_addr", b.sqz_wr_addr, i);
    end
    b.sqz_finish = 1'b1; tick(); b.sqz_finish = 1'b0;
    chk("early_error", b.error, 1);
    chk("early_busy", b.busy, 0);
    chk("early_fb", b.sqz_ram_feedback, 0);
    chk("early_sqz_en", b.sqz_en, 0);

    // new start clears error; watchdog trips at cycle 17 counted from the start cycle
    b.start = 1'b1; tick(); b.start = 1'b0;
    chk("start_clr_err", b.error, 0);
    repeat (15) tick();
    chk("wd_c16_err", b.error, 0);
    chk("wd_c16_en", b.sqz_en, 1);
    tick();
    chk("wd_c17_err", b.error, 1);
    chk("wd_c17_en", b.sqz_en, 0);
    chk("wd_c17_busy", b.busy, 0);
    tick();
    chk("wd_sticky", b.error, 1);
    b.start = 1'b1; tick(); b.start = 1'b0;
    chk("wd_clr_err", b.error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
